// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus (PC load, ROM return) and decode valid/ready handshake for fetch_ctrl.
interface fetch_ctrl_if;
  logic [31:0] pc_nxt;
  logic        pc_write;
  logic [31:0] instr_in;
  logic [31:0] pc_current;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output pc_nxt, pc_write, if_valid, if_instr, if_pc,
    input  instr_in, pc_current, if_ready
  );

  modport slave (
    input  pc_nxt, pc_write, if_valid, if_instr, if_pc,
    output instr_in, pc_current, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: PC issue, 2-cycle ROM pipe tracking, instruction FIFO to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_CTRL_MISALIGN_CHK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         halt_req,
  output logic         halted
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  ,
  output logic         fetch_fault,
  output logic [31:0]  fault_pc
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1) + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic             v0_q, v1_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem [BUF_DEPTH];
  logic [31:0]      pc_mem    [BUF_DEPTH];

  logic [31:0]      rpc;
  logic             misalign;
  logic             issue;
  logic [31:0]      issue_pc;
  logic             credit;
  logic             push, pop, flush;
  logic [CNT_W-1:0] inflight;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  assign rpc      = redirect_pc;
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign rpc      = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  // Credit counts responses still in the ROM pipe so a full FIFO is never overrun.
  assign inflight = CNT_W'(v0_q) + CNT_W'(v1_q);
  assign credit   = (count_q + inflight) < CNT_W'(BUF_DEPTH);
  assign flush    = redirect_valid;
  assign pop      = bus.if_valid && bus.if_ready;
  assign push     = v1_q && !flush;

  always_comb begin
    state_d   = state_q;
    next_pc_d = next_pc_q;
    issue     = 1'b0;
    issue_pc  = next_pc_q;
    if (redirect_valid) begin
      if (misalign) begin
        state_d = FAULT;
      end else if (halt_req) begin
        next_pc_d = rpc;
        state_d   = HALT;
      end else if (state_q == HALT) begin
        next_pc_d = rpc;
        state_d   = RUN;
      end else begin
        // Flushed buffer means the redirect target may issue without credit.
        issue     = 1'b1;
        issue_pc  = rpc;
        next_pc_d = rpc + 32'd4;
        state_d   = RUN;
      end
    end else begin
      case (state_q)
        BOOT: begin
          issue     = 1'b1;
          issue_pc  = RESET_PC;
          next_pc_d = RESET_PC + 32'd4;
          state_d   = RUN;
        end
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (credit) begin
            issue     = 1'b1;
            next_pc_d = next_pc_q + 32'd4;
          end
        end
        HALT: begin
          if (!halt_req) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // rst gates pc_write so the BOOT issue only appears once reset is released.
  assign bus.pc_write = rst && issue;
  assign bus.pc_nxt   = rst ? issue_pc : RESET_PC;
  assign bus.if_valid = (count_q != '0);
  assign bus.if_instr = bus.if_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign bus.if_pc    = bus.if_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign halted       = (state_q == HALT) && !v0_q && !v1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      next_pc_q <= RESET_PC;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      next_pc_q <= next_pc_d;
      v0_q      <= issue;
      v1_q      <= v0_q && !flush;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.instr_in;
      pc_mem[wr_ptr_q]    <= bus.pc_current;
    end
  end

`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_fault <= 1'b0;
      fault_pc    <= 32'h0;
    end else if (redirect_valid) begin
      fetch_fault <= misalign;
      if (misalign) fault_pc <= redirect_pc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register + synchronous ROM model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        halted;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  logic        fetch_fault;
  logic [31:0] fault_pc;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] pc_reg;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .halted(halted)
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    ,
    .fetch_fault(fetch_fault),
    .fault_pc(fault_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // PC register loads on pc_write; ROM output is registered one cycle later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg         <= 32'h0;
      bus.instr_in   <= 32'h0;
      bus.pc_current <= 32'h0;
    end else begin
      if (bus.pc_write) pc_reg <= bus.pc_nxt;
      bus.pc_current <= pc_reg;
      bus.instr_in   <= rom(pc_reg);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %b want 0", bus.pc_write); end
    checks++; if (bus.pc_nxt !== 32'h0) begin errors++; $display("FAIL reset_pc_nxt: got %h want 0", bus.pc_nxt); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fetch_fault: got %b want 0", fetch_fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream;
    for (int k = 0; k < 10; k++) begin
      bus.if_ready = 1'b1;
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'(4 * k)) begin errors++; $display("FAIL stream_issue k=%0d: got %b/%h want 1/%h", k, bus.pc_write, bus.pc_nxt, 32'(4 * k)); end
      if (k < 3) begin
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stream_latency k=%0d: if_valid got %b want 0", k, bus.if_valid); end
      end else begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * (k - 3)) || bus.if_instr !== rom(32'(4 * (k - 3)))) begin
          errors++; $display("FAIL stream_out k=%0d: got %b/%h/%h want 1/%h/%h", k, bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * (k - 3)), rom(32'(4 * (k - 3))));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic exp_w;
    for (int j = 0; j < 10; j++) begin
      bus.if_ready = 1'b0;
      #1;
      exp_w = (j == 0);
      checks++; if (bus.pc_write !== exp_w) begin errors++; $display("FAIL bp_pc_write j=%0d: got %b want %b", j, bus.pc_write, exp_w); end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd28) begin errors++; $display("FAIL bp_hold j=%0d: got %b/%h want 1/0000001c", j, bus.if_valid, bus.if_pc); end
      step();
    end
    for (int j = 0; j < 8; j++) begin
      bus.if_ready = 1'b1;
      #1;
      exp_w = (j >= 1);
      checks++; if (bus.pc_write !== exp_w) begin errors++; $display("FAIL bp_release_pc_write j=%0d: got %b want %b", j, bus.pc_write, exp_w); end
      if (j >= 1) begin
        checks++; if (bus.pc_nxt !== 32'(44 + 4 * (j - 1))) begin errors++; $display("FAIL bp_release_pc_nxt j=%0d: got %h want %h", j, bus.pc_nxt, 32'(44 + 4 * (j - 1))); end
      end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(28 + 4 * j) || bus.if_instr !== rom(32'(28 + 4 * j))) begin
        errors++; $display("FAIL bp_release_order j=%0d: got %b/%h/%h want 1/%h", j, bus.if_valid, bus.if_pc, bus.if_instr, 32'(28 + 4 * j));
      end
      step();
    end
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'h100) begin errors++; $display("FAIL redir_issue: got %b/%h want 1/00000100", bus.pc_write, bus.pc_nxt); end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd60) begin errors++; $display("FAIL redir_same_cycle_head: got %b/%h want 1/0000003c", bus.if_valid, bus.if_pc); end
    step();
    for (int j = 1; j < 5; j++) begin
      redirect_valid = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'(32'h100 + 4 * j)) begin errors++; $display("FAIL redir_follow j=%0d: got %b/%h want 1/%h", j, bus.pc_write, bus.pc_nxt, 32'(32'h100 + 4 * j)); end
      if (j < 3) begin
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush j=%0d: if_valid got %b (pc %h) want 0", j, bus.if_valid, bus.if_pc); end
      end else begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(32'h100 + 4 * (j - 3))) begin errors++; $display("FAIL redir_target j=%0d: got %b/%h want 1/%h", j, bus.if_valid, bus.if_pc, 32'(32'h100 + 4 * (j - 3))); end
      end
      step();
    end
  endtask

  task automatic test_halt;
    halt_req = 1'b1;
    #1;
    checks++; if (bus.pc_write !== 1'b0 || bus.if_pc !== 32'h108 || halted !== 1'b0) begin errors++; $display("FAIL halt_enter: got w=%b pc=%h halted=%b want 0/00000108/0", bus.pc_write, bus.if_pc, halted); end
    step();
    #1;
    checks++; if (bus.pc_write !== 1'b0 || bus.if_pc !== 32'h10c || halted !== 1'b0) begin errors++; $display("FAIL halt_drain1: got w=%b pc=%h halted=%b want 0/0000010c/0", bus.pc_write, bus.if_pc, halted); end
    step();
    #1;
    checks++; if (bus.pc_write !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h110 || halted !== 1'b1) begin errors++; $display("FAIL halt_drain2: got w=%b v=%b pc=%h halted=%b want 0/1/00000110/1", bus.pc_write, bus.if_valid, bus.if_pc, halted); end
    step();
    #1;
    checks++; if (bus.if_valid !== 1'b0 || halted !== 1'b1 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL halt_empty: got v=%b halted=%b w=%b want 0/1/0", bus.if_valid, halted, bus.pc_write); end
    step();
    halt_req = 1'b0;
    #1;
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL halt_release_cycle: pc_write got %b want 0", bus.pc_write); end
    step();
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'(32'h114 + 4 * j) || halted !== 1'b0) begin errors++; $display("FAIL halt_resume j=%0d: got %b/%h halted=%b want 1/%h/0", j, bus.pc_write, bus.pc_nxt, halted, 32'(32'h114 + 4 * j)); end
      if (j == 3) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h114 || bus.if_instr !== rom(32'h114)) begin errors++; $display("FAIL halt_resume_out: got %b/%h/%h want 1/00000114", bus.if_valid, bus.if_pc, bus.if_instr); end
      end
      step();
    end
  endtask

  task automatic test_async_reset;
    #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h118 || bus.pc_write !== 1'b1) begin errors++; $display("FAIL areset_before: got %b/%h/%b want 1/00000118/1", bus.if_valid, bus.if_pc, bus.pc_write); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.pc_write !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.pc_nxt !== 32'h0) begin
      errors++; $display("FAIL areset_immediate: got v=%b w=%b instr=%h pc=%h nxt=%h want all 0", bus.if_valid, bus.pc_write, bus.if_instr, bus.if_pc, bus.pc_nxt);
    end
    step();
    checks++; if (bus.if_valid !== 1'b0 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL areset_hold: got v=%b w=%b want 0/0", bus.if_valid, bus.pc_write); end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'(4 * j)) begin errors++; $display("FAIL areset_restart j=%0d: got %b/%h want 1/%h", j, bus.pc_write, bus.pc_nxt, 32'(4 * j)); end
      if (j == 3) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== rom(32'h0)) begin errors++; $display("FAIL areset_first_out: got %b/%h/%h want 1/00000000", bus.if_valid, bus.if_pc, bus.if_instr); end
      end
      step();
    end
  endtask

  task automatic test_misalign;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL mis_no_issue: pc_write got %b want 0", bus.pc_write); end
    step();
    redirect_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h102 || bus.pc_write !== 1'b0 || bus.if_valid !== 1'b0) begin
        errors++; $display("FAIL mis_fault j=%0d: got f=%b fpc=%h w=%b v=%b want 1/00000102/0/0", j, fetch_fault, fault_pc, bus.pc_write, bus.if_valid);
      end
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'h200) begin errors++; $display("FAIL mis_exit_issue: got %b/%h want 1/00000200", bus.pc_write, bus.pc_nxt); end
    step();
    redirect_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      #1;
      checks++; if (fetch_fault !== 1'b0 || bus.pc_nxt !== 32'(32'h200 + 4 * j)) begin errors++; $display("FAIL mis_exit j=%0d: got f=%b nxt=%h want 0/%h", j, fetch_fault, bus.pc_nxt, 32'(32'h200 + 4 * j)); end
      if (j == 3) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200) begin errors++; $display("FAIL mis_exit_out: got %b/%h want 1/00000200", bus.if_valid, bus.if_pc); end
      end
      step();
    end
`else
    checks++; if (bus.pc_write !== 1'b1 || bus.pc_nxt !== 32'h100) begin errors++; $display("FAIL mis_forced_align: got %b/%h want 1/00000100", bus.pc_write, bus.pc_nxt); end
    step();
    redirect_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      #1;
      checks++; if (bus.pc_nxt !== 32'(32'h100 + 4 * j)) begin errors++; $display("FAIL mis_follow j=%0d: got %h want %h", j, bus.pc_nxt, 32'(32'h100 + 4 * j)); end
      if (j == 3) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== rom(32'h100)) begin errors++; $display("FAIL mis_out: got %b/%h/%h want 1/00000100", bus.if_valid, bus.if_pc, bus.if_instr); end
      end else begin
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL mis_flush j=%0d: if_valid got %b want 0", j, bus.if_valid); end
      end
      step();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
